// File: rtl/k_exec_unit_if.sv
// Instruction-in, ALU-drive and result-out signal bundle for the execute-stage sequencer.
// slave is the sequencer's view; master is the view of whatever surrounds it.
interface k_exec_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int SEL_W  = 4,
    parameter int IMM_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  in_sel;
    logic [ADDR_W-1:0] in_rs;
    logic [ADDR_W-1:0] in_rt;
    logic [ADDR_W-1:0] in_rd;
    logic              in_use_imm;
    logic              in_load;
    logic [IMM_W-1:0]  in_imm;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [SEL_W-1:0]  alu_sel;
    logic [DATA_W-1:0] alu_res;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_rd;
    logic              out_zero;

    modport slave (
        input  in_valid, in_sel, in_rs, in_rt, in_rd, in_use_imm, in_load, in_imm,
        output in_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_res,
        output out_valid, out_data, out_rd, out_zero,
        input  out_ready
    );

    modport master (
        output in_valid, in_sel, in_rs, in_rt, in_rd, in_use_imm, in_load, in_imm,
        input  in_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_res,
        input  out_valid, out_data, out_rd, out_zero,
        output out_ready
    );
endinterface

// File: rtl/k_exec_unit.sv
// Execute-stage sequencer: IDLE -> READ -> EXEC -> WB around an external combinational ALU,
// with a 16-entry register file (R0 hard-wired to zero) fed by the writeback handshake.
module k_exec_unit #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 16,
    parameter int ADDR_W  = 4,
    parameter int SEL_W   = 4,
    parameter int IMM_W   = 16
) (
    input logic           clk,
    input logic           rst_n,
    k_exec_unit_if.slave  xu
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t              state_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [SEL_W-1:0]    sel_q;
    logic [ADDR_W-1:0]   rs_q;
    logic [ADDR_W-1:0]   rt_q;
    logic [ADDR_W-1:0]   rd_q;
    logic                use_imm_q;
    logic                load_q;
    logic [IMM_W-1:0]    imm_q;

    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic [SEL_W-1:0]    alu_sel_q;
    logic [DATA_W-1:0]   res_q;

    logic [DATA_W-1:0]   rf_q [REG_CNT];

    logic [DATA_W-1:0]   alu_a_d;
    logic [DATA_W-1:0]   alu_b_d;
    logic [DATA_W-1:0]   res_d;

    function automatic logic [DATA_W-1:0] sext(input logic signed [IMM_W-1:0] v);
        return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
    endfunction

    // Index 0 reads as zero whatever the array holds.
    always_comb begin
        alu_a_d = '0;
        alu_b_d = '0;
        if (rs_q != '0) alu_a_d = rf_q[rs_q];
        if (use_imm_q)         alu_b_d = sext(imm_q);
        else if (rt_q != '0)   alu_b_d = rf_q[rt_q];
        res_d = load_q ? sext(imm_q) : xu.alu_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sel_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            use_imm_q   <= 1'b0;
            load_q      <= 1'b0;
            imm_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_q       <= '0;
            for (int i = 0; i < REG_CNT; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xu.in_valid && in_ready_q) begin
                        sel_q      <= xu.in_sel;
                        rs_q       <= xu.in_rs;
                        rt_q       <= xu.in_rt;
                        rd_q       <= xu.in_rd;
                        use_imm_q  <= xu.in_use_imm;
                        load_q     <= xu.in_load;
                        imm_q      <= xu.in_imm;
                        in_ready_q <= 1'b0;
                        state_q    <= READ;
                    end
                end
                // ALU inputs change only here, so they are stable through all of EXEC.
                READ: begin
                    alu_a_q   <= alu_a_d;
                    alu_b_q   <= alu_b_d;
                    alu_sel_q <= sel_q;
                    state_q   <= EXEC;
                end
                EXEC: begin
                    res_q       <= res_d;
                    out_valid_q <= 1'b1;
                    state_q     <= WB;
                end
                WB: begin
                    if (xu.out_ready) begin
                        if (rd_q != '0) rf_q[rd_q] <= res_q;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign xu.in_ready  = in_ready_q;
    assign xu.alu_a     = alu_a_q;
    assign xu.alu_b     = alu_b_q;
    assign xu.alu_sel   = alu_sel_q;
    assign xu.out_valid = out_valid_q;
    assign xu.out_data  = res_q;
    assign xu.out_rd    = rd_q;
    assign xu.out_zero  = (res_q == '0);
endmodule

// File: tb/tb_k_exec_unit.sv
// Directed bench for k_exec_unit; the ALU is stubbed as alu_a + alu_b.
module tb_k_exec_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   lat;
    logic [31:0] ex_a, ex_b;
    logic [3:0]  ex_sel;

    k_exec_unit_if xu ();

    k_exec_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .xu    (xu.slave)
    );

    assign xu.alu_res = xu.alu_a + xu.alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one instruction in IDLE; optionally scramble in_* for the rest of the op.
    task automatic start_op(input logic [3:0] sel, input logic [3:0] rs, input logic [3:0] rt,
                            input logic [3:0] rd, input logic ui, input logic ld,
                            input logic [15:0] imm, input logic scr);
        xu.in_sel = sel; xu.in_rs = rs; xu.in_rt = rt; xu.in_rd = rd;
        xu.in_use_imm = ui; xu.in_load = ld; xu.in_imm = imm;
        xu.in_valid = 1'b1;
        @(posedge clk); #1;
        xu.in_valid = 1'b0;
        if (scr) begin
            xu.in_valid = 1'b1; xu.in_sel = 4'hF; xu.in_rs = 4'd3; xu.in_rt = 4'd7;
            xu.in_rd = 4'd12; xu.in_use_imm = ~ui; xu.in_load = ~ld; xu.in_imm = 16'h1234;
        end
    endtask

    // Counts edges from the accept edge until out_valid; captures ALU inputs during EXEC.
    task automatic wait_wb(output int l);
        l = 1;
        while (!xu.out_valid && l < 8) begin
            @(posedge clk); #1;
            l++;
            if (l == 2) begin
                ex_a = xu.alu_a; ex_b = xu.alu_b; ex_sel = xu.alu_sel;
            end
        end
        if (!xu.out_valid) chk("wb_timeout", {31'd0, xu.out_valid}, 32'd1);
    endtask

    task automatic finish_op();
        xu.in_valid  = 1'b0;
        xu.out_ready = 1'b1;
        @(posedge clk); #1;
        xu.out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0;
        xu.in_valid = 1'b0; xu.in_sel = '0; xu.in_rs = '0; xu.in_rt = '0; xu.in_rd = '0;
        xu.in_use_imm = 1'b0; xu.in_load = 1'b0; xu.in_imm = '0; xu.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_in_ready",  {31'd0, xu.in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, xu.out_valid}, 32'd0);
        chk("rst_alu_a",     xu.alu_a,              32'd0);
        chk("rst_alu_b",     xu.alu_b,              32'd0);
        chk("rst_alu_sel",   {28'd0, xu.alu_sel},   32'd0);
        chk("rst_out_data",  xu.out_data,           32'd0);
        chk("rst_out_rd",    {28'd0, xu.out_rd},    32'd0);
        chk("rst_out_zero",  {31'd0, xu.out_zero},  32'd1);

        start_op(4'h0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1, 16'd8, 1'b0);
        wait_wb(lat);
        chk("load_r1_data", xu.out_data, 32'd8);
        chk("load_r1_rd",   {28'd0, xu.out_rd}, 32'd1);
        finish_op();
        start_op(4'h0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b1, 16'd3, 1'b0);
        wait_wb(lat);
        chk("load_r2_data", xu.out_data, 32'd3);
        finish_op();

        // out_ready already high: handshake lands on the edge right after out_valid rises.
        xu.out_ready = 1'b1;
        start_op(4'hA, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 16'd0, 1'b0);
        wait_wb(lat);
        chk("add_latency",  lat, 32'd3);
        chk("add_alu_a",    ex_a, 32'd8);
        chk("add_alu_b",    ex_b, 32'd3);
        chk("add_alu_sel",  {28'd0, ex_sel}, 32'hA);
        chk("add_out_data", xu.out_data, 32'd11);
        chk("add_out_rd",   {28'd0, xu.out_rd}, 32'd3);
        chk("add_out_zero", {31'd0, xu.out_zero}, 32'd0);
        chk("add_wb_ready", {31'd0, xu.in_ready}, 32'd0);
        @(posedge clk); #1;
        xu.out_ready = 1'b0;
        chk("add_t3_in_ready",  {31'd0, xu.in_ready},  32'd1);
        chk("add_t3_out_valid", {31'd0, xu.out_valid}, 32'd0);

        start_op(4'h0, 4'd1, 4'd0, 4'd5, 1'b1, 1'b0, 16'hFFFF, 1'b0);
        wait_wb(lat);
        chk("sext_alu_b",    ex_b, 32'hFFFF_FFFF);
        chk("sext_out_data", xu.out_data, 32'd7);
        finish_op();

        start_op(4'h0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 16'd5, 1'b0);
        wait_wb(lat);
        finish_op();
        start_op(4'h0, 4'd0, 4'd0, 4'd6, 1'b0, 1'b0, 16'd0, 1'b0);
        wait_wb(lat);
        chk("r0_alu_a",    ex_a, 32'd0);
        chk("r0_alu_b",    ex_b, 32'd0);
        chk("r0_out_data", xu.out_data, 32'd0);
        chk("r0_out_zero", {31'd0, xu.out_zero}, 32'd1);
        finish_op();

        // R3(11) + R1(8) held in WB for 5 cycles.
        start_op(4'h0, 4'd3, 4'd1, 4'd7, 1'b0, 1'b0, 16'd0, 1'b0);
        wait_wb(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {31'd0, xu.out_valid}, 32'd1);
            chk("bp_out_data",  xu.out_data, 32'd19);
            chk("bp_out_rd",    {28'd0, xu.out_rd}, 32'd7);
            chk("bp_in_ready",  {31'd0, xu.in_ready}, 32'd0);
        end
        finish_op();
        chk("bp_release_in_ready", {31'd0, xu.in_ready}, 32'd1);
        start_op(4'h0, 4'd7, 4'd0, 4'd8, 1'b0, 1'b0, 16'd0, 1'b0);
        wait_wb(lat);
        chk("bp_r7_readback", xu.out_data, 32'd19);
        finish_op();

        // in_* toggled after accept must not disturb R1(8) + R2(3) with sel=3.
        start_op(4'h3, 4'd1, 4'd2, 4'd9, 1'b0, 1'b0, 16'd0, 1'b1);
        wait_wb(lat);
        chk("ign_alu_sel",  {28'd0, ex_sel}, 32'h3);
        chk("ign_alu_b",    ex_b, 32'd3);
        chk("ign_out_data", xu.out_data, 32'd11);
        chk("ign_out_rd",   {28'd0, xu.out_rd}, 32'd9);
        finish_op();
        xu.in_sel = '0; xu.in_rs = '0; xu.in_rt = '0; xu.in_rd = '0;
        xu.in_use_imm = 1'b0; xu.in_load = 1'b0; xu.in_imm = '0;
        start_op(4'h0, 4'd9, 4'd0, 4'd10, 1'b0, 1'b0, 16'd0, 1'b0);
        wait_wb(lat);
        chk("ign_r9_readback", xu.out_data, 32'd11);
        finish_op();

        // Abort in EXEC of an op targeting R4.
        start_op(4'h0, 4'd1, 4'd2, 4'd4, 1'b0, 1'b0, 16'd0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  {31'd0, xu.in_ready},  32'd1);
        chk("mid_rst_out_valid", {31'd0, xu.out_valid}, 32'd0);
        chk("mid_rst_alu_a",     xu.alu_a,              32'd0);
        chk("mid_rst_alu_b",     xu.alu_b,              32'd0);
        chk("mid_rst_alu_sel",   {28'd0, xu.alu_sel},   32'd0);
        chk("mid_rst_out_data",  xu.out_data,           32'd0);
        chk("mid_rst_out_rd",    {28'd0, xu.out_rd},    32'd0);
        chk("mid_rst_out_zero",  {31'd0, xu.out_zero},  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", {31'd0, xu.in_ready}, 32'd1);
        start_op(4'h0, 4'd4, 4'd1, 4'd11, 1'b0, 1'b0, 16'd0, 1'b0);
        wait_wb(lat);
        chk("post_rst_r4_alu_a", ex_a, 32'd0);
        chk("post_rst_r1_alu_b", ex_b, 32'd0);
        chk("post_rst_out_data", xu.out_data, 32'd0);
        finish_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/k_exec_unit.md
# k_exec_unit

Execute-stage sequencer that sits directly upstream of the 32-bit ALU (`K_ALU_32`). It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 16x32 register file. It drives the ALU's A, B and select inputs from registers, captures the ALU result, and writes it back to the register file. The result is also presented to the downstream consumer over a second valid/ready handshake.

## Interface
- DATA_W, 32, datapath width (ALU operand/result width)
- REG_CNT, 16, register-file entries; R0 reads as zero, writes to it are discarded
- ADDR_W, 4, register index width (log2 REG_CNT)
- SEL_W, 4, ALU select width
- IMM_W, 16, immediate width, sign-extended to DATA_W

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  block can accept an instruction (high only in IDLE)
- in_sel  in  SEL_W  ALU operation select
- in_rs  in  ADDR_W  source register for operand A
- in_rt  in  ADDR_W  source register for operand B
- in_rd  in  ADDR_W  destination register
- in_use_imm  in  1  operand B = sext(in_imm) instead of R[in_rt]
- in_load  in  1  bypass ALU: result = sext(in_imm)
- in_imm  in  IMM_W  immediate
- alu_a  out  DATA_W  registered ALU operand A
- alu_b  out  DATA_W  registered ALU operand B
- alu_sel  out  SEL_W  registered ALU select
- alu_res  in  DATA_W  combinational ALU result
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  result
- out_rd  out  ADDR_W  destination of result
- out_zero  out  1  out_data == 0

## Operation
- FSM states: IDLE, READ, EXEC, WB. Reset state IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, latch sel/rs/rt/rd/use_imm/load/imm and go to READ. Otherwise stay.
- READ: load alu_a <= R[rs]. Load alu_b <= use_imm ? sext(imm) : R[rt]. Load alu_sel <= sel. Go to EXEC.
- EXEC: res_q <= load ? sext(imm) : alu_res. Go to WB.
- WB: out_valid=1. out_data=res_q, out_rd=rd, out_zero=(res_q==0). Hold until out_ready.
  - On out_valid&out_ready: write R[rd] <= res_q (skipped if rd==0). Go to IDLE.
- Sign extension: bits [DATA_W-1:IMM_W] copy imm[IMM_W-1].
- Register reads of index 0 return 0 regardless of array contents.
- alu_a/alu_b/alu_sel hold their values outside READ. They change only on the READ edge, so the ALU inputs are stable for the whole EXEC cycle.
- Inputs in_* are ignored except in IDLE. out_ready is ignored except in WB.

## Timing
- Reset (async assert, synchronous-release assumed by system): state=IDLE, in_ready=1, out_valid=0. alu_a=alu_b=0, alu_sel=0. out_data=0, out_rd=0, out_zero=1. All REG_CNT registers = 0.
- Reset asserted mid-operation: the instruction is aborted, no writeback occurs, and all of the above values apply immediately.
- Accept edge T0 -> READ. T1 -> EXEC, with ALU inputs valid after T1. T2 -> WB, result captured and out_valid high after T2.
- If out_ready is already high, the handshake and register write happen at T3, and in_ready is high after T3.
- Minimum 4 cycles per instruction. Each extra cycle of out_ready low adds one cycle.
- No hazards: the next accept is at T4 at the earliest, and its READ at T5 sees the T3 write.
- alu_res is sampled only at the EXEC->WB edge. Its combinational path is alu_a/alu_b/alu_sel -> ALU -> res_q and must close in one cycle.

## Test plan
The bench drives alu_res from a stub returning alu_a + alu_b.
- Load then read: load R1=8 (in_load, imm=8), then load R2=3. Issue sel=4'b1010, rs=1, rt=2, rd=3.
  -> alu_a=8, alu_b=3, alu_sel=4'b1010 during EXEC. out_data=11, out_rd=3, out_zero=0.
  -> Latency T0->out_valid is exactly 3 edges.
- Immediate sign extension: in_use_imm, imm=16'hFFFF, rs=1 (R1=8) -> alu_b=32'hFFFFFFFF, out_data=7.
- R0 handling: load rd=0 imm=5, then issue rs=0, rt=0 -> alu_a=0, alu_b=0, out_data=0, out_zero=1.
- Backpressure: hold out_ready low 5 cycles in WB.
  -> out_valid, out_data and out_rd stay stable; in_ready=0; no register write until the handshake.
  -> in_ready rises the cycle after out_ready goes high.
- Ignored inputs: toggle in_valid and in_* during READ/EXEC/WB -> no effect on the latched instruction or the result.
- Reset mid-op: assert rst_n low during EXEC of an op with rd=4 -> all outputs take reset values at once. After release, R4 reads 0 and in_ready=1.
